ram_rr_arbiter: RTL and testbench
=================================

// Module: ram_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one single-port synchronous RAM (RAMS32B16KW/RAMS34B16KW class) among NREQ requesters.
//  Each requester issues read/write commands with a valid/ready handshake.
//  The block drives the RAM's active-low CE/WE, address and write data from registers.
//  Read data returns to the issuing requester with a fixed latency and a one-hot response strobe.
//  Instantiated between the CUES datapath clients and each RAMS macro; the RAM's DM and BP pins are tied off outside this block.
// PARAMETERS
//  NREQ    2    number of requesters, legal 2..4
//  DWIDTH  32   data width; must match the RAM (32 or 34)
//  AWIDTH  14   address width; must match the RAM (16384 words)
// PORTS
//  CK        in   1             clock; all logic on posedge CK
//  RB        in   1             async active-low reset
//  REQ_VLD   in   NREQ          per-requester command valid
//  REQ_WR    in   NREQ          per-requester command type: 1 = write, 0 = read
//  REQ_ADR   in   NREQ*AWIDTH   per-requester address, requester i at [i*AWIDTH +: AWIDTH]
//  REQ_WD    in   NREQ*DWIDTH   per-requester write data, packed the same way
//  REQ_RDY   out  NREQ          one-hot grant; the command transfers on the edge where VLD & RDY are both high
//  RSP_VLD   out  NREQ          one-hot read-response strobe, high for one cycle
//  RSP_DATA  out  DWIDTH        read data, valid while any RSP_VLD bit is high
//  RAM_CE    out  1             RAM chip enable, active low
//  RAM_WE    out  1             RAM write enable, active low
//  RAM_IA    out  AWIDTH        RAM address
//  RAM_I     out  DWIDTH        RAM write data
//  RAM_A     in   DWIDTH        RAM read data; the RAM updates it one edge after CE is sampled low with WE high
//  BUSY      out  1             a command or a read is in flight in pipeline stage S1 or S2
// BEHAVIOUR
//  Reset (RB low, async):
//   - RAM_CE=1, RAM_WE=1, RAM_IA=0, RAM_I=0.
//   - RSP_VLD=0, BUSY=0, pipeline valid bits cleared.
//   - Priority pointer LAST=NREQ-1, so requester 0 has top priority first.
//   - Reads in flight at reset are dropped and never answered.
//  Arbitration (combinational):
//   - Scan requesters LAST+1 .. LAST+NREQ (mod NREQ); the first with REQ_VLD high gets REQ_RDY.
//   - REQ_RDY is all zero when no REQ_VLD is high. It never depends on REQ_RDY or on any pipeline state.
//   - One command is accepted per cycle, back-to-back, with no bubbles.
//   - On acceptance LAST takes the granted index; with no acceptance LAST holds.
//  Stage S1 (registered on the accept edge E):
//   - RAM_CE=0.
//   - RAM_WE=0 for a write, 1 for a read.
//   - RAM_IA and RAM_I take the granted requester's values.
//   - S1 tag = granted index; S1 rd = ~REQ_WR.
//   - With no accept: RAM_CE=1, RAM_WE=1. RAM_IA and RAM_I hold their values.
//  Stage S2 (edge E+1): the RAM acts (write, or read into RAM_A). S2 valid = S1 valid & S1 rd; S2 tag = S1 tag.
//  Response (cycle after edge E+2):
//   - RSP_VLD[S2 tag] = S2 valid.
//   - RSP_DATA = RAM_A, passed through combinationally. RSP_DATA is don't-care when RSP_VLD=0.
//   - Read latency = 2 edges after acceptance. There is no response backpressure; requesters must sink it.
//   - Writes produce no response.
//  Ordering:
//   - Responses return in acceptance order.
//   - A read immediately after a write to the same address returns the new data, because the RAM serialises them.
//  Boundaries:
//   - A requester that drops VLD without RDY loses nothing; its command is simply not taken.
//   - A requester that holds VLD continuously with all others idle is granted every cycle.
//   - RAM_IA wraps naturally: address 2^AWIDTH-1 is legal; there is no address checking.
//   - BUSY = S1 valid | S2 valid.
// TESTING
//  1. Reset: hold RB=0 with all REQ_VLD=1 -> RAM_CE=1, RAM_WE=1, RSP_VLD=0, REQ_RDY still =0001 (combinational).
//  2. Single write then read: req0 writes 0x1234_5678 to 0x0005, next cycle reads 0x0005
//     -> RAM_CE low 2 cycles, RAM_WE low only in the first; RSP_VLD=01 with 0x12345678 two edges after the read accept.
//  3. Round-robin: NREQ=4, all VLD held high 8 cycles -> grant order 0,1,2,3,0,1,2,3; never two RDY bits high.
//  4. Fairness skip: VLD=1010 after last grant 1 -> grants 3,1,3,1.
//  5. Back-to-back reads: req0 at 0x3FFF, req1 at 0x0000, preloaded 0xAAAA_0001 / 0x5555_0002
//     -> RSP_VLD=01 then 10 on consecutive cycles with matching data.
//  6. Mid-flight reset: assert RB low one cycle after a read accept
//     -> no RSP_VLD ever appears for it; first post-reset grant goes to req0.

Source files
------------

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NREQ requesters.
// Commands are registered onto the RAM pins; read data returns two edges after acceptance.
module ram_rr_arbiter #(
  parameter int NREQ   = 2,
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 14
) (
  input  logic                     CK,
  input  logic                     RB,
  input  logic [NREQ-1:0]          REQ_VLD,
  input  logic [NREQ-1:0]          REQ_WR,
  input  logic [NREQ*AWIDTH-1:0]   REQ_ADR,
  input  logic [NREQ*DWIDTH-1:0]   REQ_WD,
  output logic [NREQ-1:0]          REQ_RDY,
  output logic [NREQ-1:0]          RSP_VLD,
  output logic [DWIDTH-1:0]        RSP_DATA,
  output logic                     RAM_CE,
  output logic                     RAM_WE,
  output logic [AWIDTH-1:0]        RAM_IA,
  output logic [DWIDTH-1:0]        RAM_I,
  input  logic [DWIDTH-1:0]        RAM_A,
  output logic                     BUSY
);

  localparam int IW = (NREQ > 2) ? 2 : 1;
  localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE      = {{(NREQ-1){1'b0}}, 1'b1};

  logic [IW-1:0]     r_last;
  logic              r_ce;
  logic              r_we;
  logic [AWIDTH-1:0] r_ia;
  logic [DWIDTH-1:0] r_i;
  logic              r_s1_vld;
  logic              r_s1_rd;
  logic [IW-1:0]     r_s1_tag;
  logic              r_s2_vld;
  logic [IW-1:0]     r_s2_tag;
  logic [NREQ-1:0]   r_rsp_vld;

  logic [NREQ-1:0]   w_rdy;
  logic              w_gnt_any;
  logic [IW-1:0]     w_gnt_idx;
  logic [IW-1:0]     w_idx;
  logic              w_hit;
  logic              w_gnt_wr;
  logic [AWIDTH-1:0] w_adr;
  logic [DWIDTH-1:0] w_wd;

  // Rotating-priority scan starting just after the last granted requester
  always_comb begin
    w_rdy     = '0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    w_hit     = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx     = IW'((int'(r_last) + k) % NREQ);
      w_hit     = ~w_gnt_any & REQ_VLD[w_idx];
      w_rdy     = w_rdy | (w_hit ? (ONE << w_idx) : '0);
      w_gnt_idx = w_hit ? w_idx : w_gnt_idx;
      w_gnt_any = w_gnt_any | w_hit;
    end
  end

  // One-hot AND-OR select of the granted command fields
  always_comb begin
    w_adr    = '0;
    w_wd     = '0;
    w_gnt_wr = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_adr    = w_adr | (REQ_ADR[i*AWIDTH +: AWIDTH] & {AWIDTH{w_rdy[i]}});
      w_wd     = w_wd  | (REQ_WD[i*DWIDTH +: DWIDTH]  & {DWIDTH{w_rdy[i]}});
      w_gnt_wr = w_gnt_wr | (REQ_WR[i] & w_rdy[i]);
    end
  end

  // Priority pointer follows each accepted grant
  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      r_last <= LAST_RST;
    end else if (w_gnt_any) begin
      r_last <= w_gnt_idx;
    end else begin
      r_last <= r_last;
    end
  end

  // Stage S1: drive the RAM pins from the accepted command
  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      r_ce     <= 1'b1;
      r_we     <= 1'b1;
      r_ia     <= '0;
      r_i      <= '0;
      r_s1_vld <= 1'b0;
      r_s1_rd  <= 1'b0;
      r_s1_tag <= '0;
    end else if (w_gnt_any) begin
      r_ce     <= 1'b0;
      r_we     <= ~w_gnt_wr;
      r_ia     <= w_adr;
      r_i      <= w_wd;
      r_s1_vld <= 1'b1;
      r_s1_rd  <= ~w_gnt_wr;
      r_s1_tag <= w_gnt_idx;
    end else begin
      r_ce     <= 1'b1;
      r_we     <= 1'b1;
      r_s1_vld <= 1'b0;
      r_s1_rd  <= 1'b0;
    end
  end

  // Stage S2 and response strobe; RAM_A is valid in the same cycle as the strobe
  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      r_s2_vld  <= 1'b0;
      r_s2_tag  <= '0;
      r_rsp_vld <= '0;
    end else begin
      r_s2_vld  <= r_s1_vld & r_s1_rd;
      r_s2_tag  <= r_s1_tag;
      r_rsp_vld <= r_s2_vld ? (ONE << r_s2_tag) : '0;
    end
  end

  assign REQ_RDY  = w_rdy;
  assign RSP_VLD  = r_rsp_vld;
  assign RSP_DATA = RAM_A;
  assign RAM_CE   = r_ce;
  assign RAM_WE   = r_we;
  assign RAM_IA   = r_ia;
  assign RAM_I    = r_i;
  assign BUSY     = r_s1_vld | r_s2_vld;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter (NREQ=4) with a behavioural single-port RAM.
module tb_ram_rr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int AW   = 14;

  logic                 ck = 1'b0;
  logic                 rb;
  logic [NREQ-1:0]      req_vld;
  logic [NREQ-1:0]      req_wr;
  logic [NREQ*AW-1:0]   req_adr;
  logic [NREQ*DW-1:0]   req_wd;
  logic [NREQ-1:0]      req_rdy;
  logic [NREQ-1:0]      rsp_vld;
  logic [DW-1:0]        rsp_data;
  logic                 ram_ce;
  logic                 ram_we;
  logic [AW-1:0]        ram_ia;
  logic [DW-1:0]        ram_i;
  logic [DW-1:0]        ram_a = '0;
  logic                 busy;

  logic [DW-1:0]        mem [0:(1<<AW)-1];
  logic                 pend = 1'b0;
  logic [DW-1:0]        pend_d = '0;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [NREQ-1:0] vld;
    logic [NREQ-1:0] exp_rdy;
  } vec_t;
  vec_t tbl [18];

  ram_rr_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .CK(ck), .RB(rb),
    .REQ_VLD(req_vld), .REQ_WR(req_wr), .REQ_ADR(req_adr), .REQ_WD(req_wd),
    .REQ_RDY(req_rdy), .RSP_VLD(rsp_vld), .RSP_DATA(rsp_data),
    .RAM_CE(ram_ce), .RAM_WE(ram_we), .RAM_IA(ram_ia), .RAM_I(ram_i),
    .RAM_A(ram_a), .BUSY(busy)
  );

  always #5 ck = ~ck;

  // RAM model: samples CE/WE at an edge, read data appears on RAM_A one edge later
  always @(posedge ck) begin
    if (pend) ram_a <= pend_d;
    pend   <= ~ram_ce & ram_we;
    pend_d <= mem[ram_ia];
    if (~ram_ce & ~ram_we) mem[ram_ia] <= ram_i;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  function automatic logic [AW-1:0] oh_idx(input logic [NREQ-1:0] oh);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) r = AW'(i);
    return r;
  endfunction

  initial begin
    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};
    tbl[5]  = '{4'b1111, 4'b0010};
    tbl[6]  = '{4'b1111, 4'b0100};
    tbl[7]  = '{4'b1111, 4'b1000};
    tbl[8]  = '{4'b0000, 4'b0000};
    tbl[9]  = '{4'b0010, 4'b0010};
    tbl[10] = '{4'b1010, 4'b1000};
    tbl[11] = '{4'b1010, 4'b0010};
    tbl[12] = '{4'b1010, 4'b1000};
    tbl[13] = '{4'b1010, 4'b0010};
    tbl[14] = '{4'b0101, 4'b0100};
    tbl[15] = '{4'b0101, 4'b0001};
    tbl[16] = '{4'b0001, 4'b0001};
    tbl[17] = '{4'b0001, 4'b0001};

    // Reset held with every requester asking
    rb      = 1'b0;
    req_vld = 4'b1111;
    req_wr  = 4'b0000;
    req_adr = {14'd3, 14'd2, 14'd1, 14'd0};
    req_wd  = '0;
    repeat (2) @(posedge ck);
    #1;
    chk("rst_ce", 64'(ram_ce), 64'h1);
    chk("rst_we", 64'(ram_we), 64'h1);
    chk("rst_rsp", 64'(rsp_vld), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_rdy", 64'(req_rdy), 64'h1);
    chk("rst_ia", 64'(ram_ia), 64'h0);
    chk("rst_i", 64'(ram_i), 64'h0);
    req_vld = 4'b0000;
    rb      = 1'b1;
    tick();

    // Round-robin order and fairness skip
    for (int i = 0; i < 18; i++) begin
      req_vld = tbl[i].vld;
      #1;
      chk($sformatf("tbl_rdy[%0d]", i), 64'(req_rdy), 64'(tbl[i].exp_rdy));
      chk($sformatf("tbl_onehot[%0d]", i), 64'($countones(req_rdy) <= 1), 64'h1);
      tick();
      chk($sformatf("tbl_ce[%0d]", i), 64'(ram_ce), 64'(tbl[i].exp_rdy == 4'b0000));
      if (tbl[i].exp_rdy != 4'b0000)
        chk($sformatf("tbl_ia[%0d]", i), 64'(ram_ia), 64'(oh_idx(tbl[i].exp_rdy)));
    end
    req_vld = 4'b0000;
    repeat (4) tick();
    chk("drain_busy", 64'(busy), 64'h0);
    chk("drain_rsp", 64'(rsp_vld), 64'h0);

    // Write then read of the same address from requester 0
    req_adr[0*AW +: AW] = 14'h0005;
    req_wd[0*DW +: DW]  = 32'h1234_5678;
    req_wr  = 4'b0001;
    req_vld = 4'b0001;
    #1;
    chk("wr_rdy", 64'(req_rdy), 64'h1);
    tick();
    chk("wr_ce", 64'(ram_ce), 64'h0);
    chk("wr_we", 64'(ram_we), 64'h0);
    chk("wr_ia", 64'(ram_ia), 64'h5);
    chk("wr_i", 64'(ram_i), 64'h1234_5678);
    chk("wr_busy", 64'(busy), 64'h1);
    req_wr = 4'b0000;
    #1;
    chk("rd_rdy", 64'(req_rdy), 64'h1);
    tick();
    chk("rd_ce", 64'(ram_ce), 64'h0);
    chk("rd_we", 64'(ram_we), 64'h1);
    chk("rd_rsp_e1", 64'(rsp_vld), 64'h0);
    req_vld = 4'b0000;
    tick();
    chk("idle_ce", 64'(ram_ce), 64'h1);
    chk("idle_we", 64'(ram_we), 64'h1);
    chk("idle_ia_hold", 64'(ram_ia), 64'h5);
    chk("rd_rsp_e2", 64'(rsp_vld), 64'h0);
    tick();
    chk("rd_rsp", 64'(rsp_vld), 64'h1);
    chk("rd_data", 64'(rsp_data), 64'h1234_5678);
    tick();
    chk("rd_rsp_end", 64'(rsp_vld), 64'h0);
    chk("rd_busy_end", 64'(busy), 64'h0);

    // Preload edge addresses, then back-to-back reads from two requesters
    req_adr[0*AW +: AW] = 14'h3FFF;
    req_wd[0*DW +: DW]  = 32'hAAAA_0001;
    req_wr  = 4'b0001;
    req_vld = 4'b0001;
    tick();
    req_adr[1*AW +: AW] = 14'h0000;
    req_wd[1*DW +: DW]  = 32'h5555_0002;
    req_wr  = 4'b0010;
    req_vld = 4'b0010;
    #1;
    chk("pre_rdy1", 64'(req_rdy), 64'h2);
    tick();
    req_wr  = 4'b0000;
    req_vld = 4'b0011;
    #1;
    chk("b2b_rdy0", 64'(req_rdy), 64'h1);
    tick();
    chk("b2b_ia0", 64'(ram_ia), 64'h3FFF);
    chk("b2b_rdy1", 64'(req_rdy), 64'h2);
    tick();
    chk("b2b_ia1", 64'(ram_ia), 64'h0);
    req_vld = 4'b0000;
    tick();
    chk("b2b_rsp0", 64'(rsp_vld), 64'h1);
    chk("b2b_data0", 64'(rsp_data), 64'hAAAA_0001);
    tick();
    chk("b2b_rsp1", 64'(rsp_vld), 64'h2);
    chk("b2b_data1", 64'(rsp_data), 64'h5555_0002);
    tick();
    chk("b2b_rsp_end", 64'(rsp_vld), 64'h0);

    // Reset while a read is in flight: it must never be answered
    req_adr[2*AW +: AW] = 14'h0005;
    req_vld = 4'b0100;
    #1;
    chk("mf_rdy", 64'(req_rdy), 64'h4);
    tick();
    req_vld = 4'b0000;
    tick();
    chk("mf_busy_pre", 64'(busy), 64'h1);
    rb = 1'b0;
    #1;
    chk("mf_busy_rst", 64'(busy), 64'h0);
    chk("mf_ce_rst", 64'(ram_ce), 64'h1);
    chk("mf_rsp_rst", 64'(rsp_vld), 64'h0);
    repeat (2) tick();
    rb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mf_rsp_post[%0d]", i), 64'(rsp_vld), 64'h0);
    end
    req_vld = 4'b1111;
    #1;
    chk("mf_first_rdy", 64'(req_rdy), 64'h1);
    tick();
    chk("mf_first_ia", 64'(ram_ia), 64'h3FFF);
    req_vld = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
